// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and defaults for the skid pipeline stage
package pipe_pkg;

  localparam int PIPE_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter, sticks at all-ones
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer stage with flush, registered valid/ready
// Optional stall/bubble/flush counters under PIPE_STAGE_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = PIPE_CNT_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
`endif
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              xfer;

  assign o_valid = (state_q != EMPTY);
  assign o_ready = (state_q != FULL);
  assign o_data  = main_q;

  assign accept = i_valid && o_ready && !i_flush;
  assign xfer   = o_valid && i_ready && !i_flush;

  // main is zeroed on every path into EMPTY so o_data reads 0 whenever o_valid is low
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = i_data;
          end
        end
        BUSY: begin
          case ({accept, xfer})
            2'b11: main_d = i_data;
            2'b10: begin
              state_d = FULL;
              skid_d  = i_data;
            end
            2'b01: begin
              state_d = EMPTY;
              main_d  = '0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (xfer) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;
  logic flush_inc;

  assign stall_inc  = o_valid && !i_ready;
  assign bubble_inc = !o_valid && !i_flush;
  assign flush_inc  = i_flush && (state_q != EMPTY);

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (stall_inc),
    .o_cnt   (o_stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (bubble_inc),
    .o_cnt   (o_bubble_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (flush_inc),
    .o_cnt   (o_flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage (counters under PIPE_STAGE_PERF_EN)
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready_o;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          ds_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  logic          mon_en = 1'b0;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (in_valid),
    .o_ready      (out_ready_o),
    .i_data       (in_data),
    .i_flush      (flush),
    .o_valid      (out_valid),
    .i_ready      (ds_ready),
    .o_data       (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt),
    .o_flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got=%0d pending expected=0 pending", name, exp_q.size());
    end
  endtask

  // Monitor: every downstream transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid && ds_ready && !flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got=%h expected=none", out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got=%h expected=%h", out_data, e);
          end
        end
      end
      if (!out_valid) begin
        checks++;
        if (out_data !== '0) begin
          errors++;
          $display("FAIL zero_on_empty: got=%h expected=0", out_data);
        end
      end
    end
  end

  logic [DW-1:0] tput_vec [6] = '{32'hDEAD_0001, 32'hBEEF_0002, 32'h0000_0000,
                                  32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    ds_ready = 1'b0;
    #2;
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_ready", DW'(out_ready_o), 1);
    chk("rst_data", out_data, 0);
    mon_en = 1'b1;

    // streaming, first payload accepted on first edge after release
    @(negedge clk);
    ds_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1;
    exp_q.push_back(32'h1);
    rst_n    = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("stream_ready", DW'(out_ready_o), 1);
      chk("stream_latency", out_data, DW'(k - 1));
      in_data = DW'(k);
      exp_q.push_back(DW'(k));
    end
    cyc();
    in_valid = 1'b0;
    wait_drain("stream");

    // sustained throughput
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = tput_vec[k];
      exp_q.push_back(tput_vec[k]);
      cyc();
      chk("tput_ready", DW'(out_ready_o), 1);
    end
    in_valid = 1'b0;
    wait_drain("tput");

    // backpressure into FULL, then release
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA;
    exp_q.push_back(32'hA);
    cyc();
    in_data  = 32'hB;
    exp_q.push_back(32'hB);
    cyc();
    in_valid = 1'b0;
    chk("bp_ready", DW'(out_ready_o), 0);
    chk("bp_valid", DW'(out_valid), 1);
    chk("bp_data", out_data, 32'hA);
    cyc();
    chk("bp_hold1", out_data, 32'hA);
    cyc();
    chk("bp_hold2", out_data, 32'hA);
    ds_ready = 1'b1;
    wait_drain("bp");
    chk("bp_empty", DW'(out_valid), 0);

    // flush in FULL with a simultaneous incoming payload
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hA;
    exp_q.push_back(32'hA);
    cyc();
    in_data  = 32'hB;
    exp_q.push_back(32'hB);
    cyc();
    in_data  = 32'hC;
    flush    = 1'b1;
    cyc();
    exp_q.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", DW'(out_valid), 0);
    chk("fl_data", out_data, 0);
    chk("fl_ready", DW'(out_ready_o), 1);
    ds_ready = 1'b1;
    repeat (4) cyc();
    chk("fl_stays_empty", DW'(out_valid), 0);

    // flush in BUSY and in EMPTY, incoming payloads discarded
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h11;
    exp_q.push_back(32'h11);
    cyc();
    in_data  = 32'h22;
    flush    = 1'b1;
    cyc();
    exp_q.delete();
    chk("fl_busy_valid", DW'(out_valid), 0);
    in_data  = 32'h77;
    cyc();
    chk("fl_empty_valid", DW'(out_valid), 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    ds_ready = 1'b1;
    repeat (3) cyc();

    // asynchronous reset while FULL
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h5;
    exp_q.push_back(32'h5);
    cyc();
    in_data  = 32'h6;
    exp_q.push_back(32'h6);
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_ready", DW'(out_ready_o), 0);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", DW'(out_valid), 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", DW'(out_ready_o), 1);
    ds_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("post_rst_valid", DW'(out_valid), 0);

    // unknown data while idle must not reach the outputs
    in_valid = 1'b0;
    in_data  = 'x;
    cyc();
    chk("x_data", out_data, 0);
    chk("x_valid", DW'(out_valid), 0);
    in_data  = '0;

`ifdef PIPE_STAGE_PERF_EN
    rst_n = 1'b0;
    #1;
    chk("cnt_rst_stall", DW'(stall_cnt), 0);
    chk("cnt_rst_flush", DW'(flush_cnt), 0);
    #1;
    rst_n    = 1'b1;
    ds_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h99;
    exp_q.push_back(32'h99);
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("stall_sat", DW'(stall_cnt), 15);
    chk("flush_pre", DW'(flush_cnt), 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_cnt", DW'(flush_cnt), 1);
    repeat (20) cyc();
    chk("bubble_sat", DW'(bubble_cnt), 15);
`endif

    wait_drain("final");
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, legal range 1..512.
REQ-002 Parameter CNT_W, default 16: performance counter width, used only when PIPE_STAGE_PERF_EN is defined.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  upstream payload valid.
REQ-006 o_ready  output  1  stage can accept a payload this cycle.
REQ-007 i_data  input  DATA_W  upstream payload.
REQ-008 i_flush  input  1  discard all held and incoming payloads.
REQ-009 o_valid  output  1  downstream payload valid.
REQ-010 i_ready  input  1  downstream accepts the payload this cycle.
REQ-011 o_data  output  DATA_W  downstream payload.
REQ-012 o_stall_cnt, o_bubble_cnt, o_flush_cnt  output  CNT_W each  performance counters; present only with PIPE_STAGE_PERF_EN.

Function
REQ-013 Accept event = i_valid && o_ready && !i_flush; transfer event = o_valid && i_ready && !i_flush.
REQ-014 Storage: main entry (drives o_data) plus one skid entry; state EMPTY (none valid), BUSY (main only), FULL (main and skid).
REQ-015 o_valid = state != EMPTY; o_ready = state != FULL; both derive from registers only, with no combinational path from i_ready or i_valid.
REQ-016 EMPTY: accept -> BUSY, main <= i_data; otherwise hold.
REQ-017 BUSY: accept and transfer -> BUSY, main <= i_data; accept only -> FULL, skid <= i_data; transfer only -> EMPTY; neither -> hold.
REQ-018 FULL: transfer -> BUSY, main <= skid, skid cleared to 0; no transfer -> hold; no accept is possible (o_ready=0).
REQ-019 Latency: a payload accepted at edge N appears on o_data with o_valid=1 after edge N when the stage was EMPTY.
REQ-020 Throughput: with i_ready held at 1, the stage accepts and delivers one payload per cycle indefinitely.
REQ-021 Order: payloads leave in exactly the order accepted; none is duplicated or dropped except on flush.
REQ-022 Stability: while o_valid=1 and i_ready=0, o_data holds its value unchanged.
REQ-023 Flush: i_flush=1 at an edge forces EMPTY and clears main and skid to 0, from any state; it has priority over accept and transfer, and a simultaneous i_valid payload is discarded.
REQ-024 Zero-on-empty: whenever o_valid=0, o_data = 0; main is cleared on drain to EMPTY.
REQ-025 Outputs shall carry no X after reset regardless of input X on i_data while i_valid=0.

Reset
REQ-026 i_rst_n=0 shall asynchronously force state EMPTY, main=0, skid=0, o_valid=0, o_ready=1, o_data=0, and all counters to 0.
REQ-027 Reset asserted mid-operation shall discard all held payloads, with no transfer completing on the deassertion edge.
REQ-028 The first accept is permitted on the first rising edge after deassertion.

Configuration
REQ-029 With PIPE_STAGE_PERF_EN defined, o_stall_cnt increments each cycle with o_valid && !i_ready.
REQ-030 With PIPE_STAGE_PERF_EN defined, o_bubble_cnt increments each cycle with !o_valid && !i_flush.
REQ-031 With PIPE_STAGE_PERF_EN defined, o_flush_cnt increments on each flush edge where state != EMPTY.
REQ-032 All counters shall saturate at all-ones and never wrap.
REQ-033 Without PIPE_STAGE_PERF_EN, counter ports and logic are absent, and datapath behaviour is identical.

Structure
REQ-034 Shared package pipe_pkg holds typedef pipe_state_e (EMPTY, BUSY, FULL) and the constant PIPE_CNT_W_DEFAULT=16.
REQ-035 Sub-module pipe_sat_counter (parameter W; inputs i_clk, i_rst_n, i_inc; output o_cnt) implements one saturating counter and is instantiated three times under the macro.

Verification
REQ-036 Streaming: reset, then i_ready=1 and i_valid=1 with data 0x1,0x2,0x3,0x4 on consecutive cycles -> o_data 0x1..0x4 one cycle later each, o_ready constantly 1.
REQ-037 Backpressure: i_ready=0, send 0xA then 0xB -> FULL, o_ready=0, o_data=0xA held; raise i_ready -> 0xA then 0xB delivered, final state EMPTY.
REQ-038 Flush in FULL: hold 0xA/0xB with i_valid=1 carrying 0xC and i_flush=1 -> next cycle o_valid=0, o_data=0, o_ready=1; 0xC is never delivered.
REQ-039 Mid-operation reset: with state FULL, pulse i_rst_n low between clock edges -> o_valid=0, o_data=0, o_ready=1 immediately; no payload appears after release.
REQ-040 Counter saturation (macro on, CNT_W=4): 20 cycles of o_valid=1, i_ready=0 -> o_stall_cnt=15; then one flush -> o_flush_cnt=1.
